ddr3_avl_arbiter: RTL and testbench

Shares the single DDR3 Avalon-MM port between two masters: the display read path (burst read commands) and a frame write path (multi-beat write bursts). The block sits in the ddr3_clk domain between the requesters and the DDR3 controller. It grants whole bursts and holds the bus for the full length of a write burst. Reads have priority; an optional starvation guard bounds how long a pending write can wait.

---
 rtl/ddr3_avl_arbiter.sv | 151 +++++++++++++++
 tb/tb_ddr3_avl_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_avl_arbiter.sv
// ddr3_avl_arbiter: shares one DDR3 Avalon-MM port between a burst-read
// requester and a multi-beat write requester. Whole bursts are granted; the
// bus is held for the full length of a write burst. Reads win ties.
// Optional starvation guard: define DDR3_ARB_STARVE_GUARD_EN to bound the
// number of consecutive read grants made while a write is waiting.
module ddr3_avl_arbiter #(
  parameter int ADDR_W          = 26,
  parameter int DATA_W          = 128,
  parameter int RD_STARVE_LIMIT = 8
) (
  input  logic                ddr3_clk,
  input  logic                reset_n,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic [2:0]          rd_size,
  output logic                rd_ack,
  input  logic                wr_req,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [2:0]          wr_size,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  output logic                wr_ack,
  input  logic                ddr3_avl_ready,
  output logic                ddr3_avl_burstbegin,
  output logic [2:0]          ddr3_avl_size,
  output logic [ADDR_W-1:0]   ddr3_avl_addr,
  output logic                ddr3_avl_read_req,
  output logic                ddr3_avl_write_req,
  output logic [DATA_W-1:0]   ddr3_avl_wdata,
  output logic [DATA_W/8-1:0] ddr3_avl_be,
  output logic                wr_busy
);

  typedef enum logic [1:0] {IDLE, RD_CMD, WR_BURST} state_t;

  state_t            state;
  logic [ADDR_W-1:0] burst_addr;
  logic [2:0]        burst_size;
  logic [2:0]        beat_cnt;
  logic              burstbegin;
  logic              read_req;
  logic              write_req;

  logic              guard_fire;
  logic              grant_rd;
  logic              grant_wr;
  logic [2:0]        rd_len;
  logic [2:0]        wr_len;

  // A zero-length request is a single-beat burst.
  assign rd_len = (rd_size == 3'd0) ? 3'd1 : rd_size;
  assign wr_len = (wr_size == 3'd0) ? 3'd1 : wr_size;

  // Reads win unless a waiting write has been passed over too many times.
  assign grant_rd = rd_req && !(wr_req && guard_fire);
  assign grant_wr = wr_req && !grant_rd;

`ifdef DDR3_ARB_STARVE_GUARD_EN
  logic [7:0] starve_cnt;

  assign guard_fire = (starve_cnt >= 8'(RD_STARVE_LIMIT));

  // Count read grants that bypass a pending write; a write grant clears it.
  always_ff @(posedge ddr3_clk) begin
    if (!reset_n) begin
      starve_cnt <= 8'd0;
    end else if (state == IDLE) begin
      if (grant_wr) begin
        starve_cnt <= 8'd0;
      end else if (grant_rd && wr_req && (starve_cnt != 8'hFF)) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
    end
  end
`else
  // Strict read priority: the guard never fires and the limit has no effect.
  assign guard_fire = 1'b0 && (RD_STARVE_LIMIT != 0);
`endif

  // Arbitration and burst sequencing; every Avalon command output is registered.
  always_ff @(posedge ddr3_clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      burst_addr <= '0;
      burst_size <= 3'd0;
      beat_cnt   <= 3'd0;
      burstbegin <= 1'b0;
      read_req   <= 1'b0;
      write_req  <= 1'b0;
    end else begin
      burstbegin <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_rd) begin
            state      <= RD_CMD;
            burst_addr <= rd_addr;
            burst_size <= rd_len;
            beat_cnt   <= rd_len;
            read_req   <= 1'b1;
            burstbegin <= 1'b1;
          end else if (grant_wr) begin
            state      <= WR_BURST;
            burst_addr <= wr_addr;
            burst_size <= wr_len;
            beat_cnt   <= wr_len;
            write_req  <= 1'b1;
            burstbegin <= 1'b1;
          end
        end
        RD_CMD: begin
          if (ddr3_avl_ready) begin
            state      <= IDLE;
            read_req   <= 1'b0;
            burst_addr <= '0;
            burst_size <= 3'd0;
            beat_cnt   <= 3'd0;
          end
        end
        WR_BURST: begin
          if (ddr3_avl_ready) begin
            if (beat_cnt == 3'd1) begin
              state      <= IDLE;
              write_req  <= 1'b0;
              burst_addr <= '0;
              burst_size <= 3'd0;
              beat_cnt   <= 3'd0;
            end else begin
              beat_cnt <= beat_cnt - 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ddr3_avl_burstbegin = burstbegin;
  assign ddr3_avl_size       = burst_size;
  assign ddr3_avl_addr       = burst_addr;
  assign ddr3_avl_read_req   = read_req;
  assign ddr3_avl_write_req  = write_req;
  assign wr_busy             = (state == WR_BURST);

  // Acks follow the controller's ready directly; write data passes straight
  // through while a write burst owns the bus and is held at zero otherwise.
  assign rd_ack         = (state == RD_CMD) && ddr3_avl_ready;
  assign wr_ack         = (state == WR_BURST) && ddr3_avl_ready;
  assign ddr3_avl_wdata = (state == WR_BURST) ? wr_data : '0;
  assign ddr3_avl_be    = (state == WR_BURST) ? wr_be : '0;

endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// tb_ddr3_avl_arbiter: directed test-plan steps followed by a randomized run,
// all checked against a transaction-level model of the arbitration rules.
module tb_ddr3_avl_arbiter;

  localparam int ADDR_W       = 26;
  localparam int DATA_W       = 128;
  localparam int STARVE_LIMIT = 3;

  logic                ddr3_clk = 1'b0;
  logic                reset_n  = 1'b0;
  logic                rd_req   = 1'b0;
  logic [ADDR_W-1:0]   rd_addr  = '0;
  logic [2:0]          rd_size  = 3'd0;
  logic                rd_ack;
  logic                wr_req   = 1'b0;
  logic [ADDR_W-1:0]   wr_addr  = '0;
  logic [2:0]          wr_size  = 3'd0;
  logic [DATA_W-1:0]   wr_data  = '0;
  logic [DATA_W/8-1:0] wr_be    = '0;
  logic                wr_ack;
  logic                ddr3_avl_ready = 1'b0;
  logic                ddr3_avl_burstbegin;
  logic [2:0]          ddr3_avl_size;
  logic [ADDR_W-1:0]   ddr3_avl_addr;
  logic                ddr3_avl_read_req;
  logic                ddr3_avl_write_req;
  logic [DATA_W-1:0]   ddr3_avl_wdata;
  logic [DATA_W/8-1:0] ddr3_avl_be;
  logic                wr_busy;

  ddr3_avl_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .ddr3_clk(ddr3_clk), .reset_n(reset_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_size(rd_size), .rd_ack(rd_ack),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size),
    .wr_data(wr_data), .wr_be(wr_be), .wr_ack(wr_ack),
    .ddr3_avl_ready(ddr3_avl_ready), .ddr3_avl_burstbegin(ddr3_avl_burstbegin),
    .ddr3_avl_size(ddr3_avl_size), .ddr3_avl_addr(ddr3_avl_addr),
    .ddr3_avl_read_req(ddr3_avl_read_req), .ddr3_avl_write_req(ddr3_avl_write_req),
    .ddr3_avl_wdata(ddr3_avl_wdata), .ddr3_avl_be(ddr3_avl_be), .wr_busy(wr_busy)
  );

  always #5 ddr3_clk = ~ddr3_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: which burst owns the bus (0 none, 1 read, 2 write).
  int                m_kind   = 0;
  int                m_first  = 0;
  int                m_left   = 0;
  int                m_starve = 0;
  logic [ADDR_W-1:0] m_addr   = '0;
  logic [2:0]        m_size   = 3'd0;

  // Requester-side bookkeeping.
  int wr_beat   = 0;
  bit auto_rd   = 0;
  bit auto_wr   = 0;
  bit rand_mode = 0;
  int grant_log[$];

  // Snapshot of DUT outputs at the last sample point.
  logic              obs_read_req, obs_write_req, obs_bb, obs_rd_ack, obs_wr_ack, obs_busy;
  logic [ADDR_W-1:0] obs_addr;
  logic [2:0]        obs_size;
  logic [DATA_W-1:0] obs_wdata;

  int pat[6] = '{1, 0, 1, 1, 0, 1};
  int exp_seq[8];
  int acks;

  function automatic int nz(input logic [2:0] s);
    return (s == 3'd0) ? 1 : int'(s);
  endfunction

  function automatic logic [DATA_W-1:0] beat_data(input logic [ADDR_W-1:0] a, input int b);
    return {6'd0, a, 32'(b) ^ 32'h5A5A_0000, ~{6'd0, a}, 32'h1234_0000 + 32'(b)};
  endfunction

  function automatic logic [DATA_W/8-1:0] beat_be(input logic [ADDR_W-1:0] a, input int b);
    return 16'(b * 16'h1111) ^ a[15:0];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic update_wdata();
    wr_data = beat_data(wr_addr, wr_beat);
    wr_be   = beat_be(wr_addr, wr_beat);
  endtask

  task automatic raise_rd(input logic [ADDR_W-1:0] a, input logic [2:0] s);
    rd_req  = 1'b1;
    rd_addr = a;
    rd_size = s;
  endtask

  task automatic raise_wr(input logic [ADDR_W-1:0] a, input logic [2:0] s);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_size = s;
    wr_beat = 0;
    update_wdata();
  endtask

  // One clock cycle: sample and check at the falling edge, advance the model,
  // then let the requesters react just after the rising edge.
  task automatic tick();
    bit guard;
    bit rd_acked;
    bit wr_acked;
    @(negedge ddr3_clk);
    obs_read_req  = ddr3_avl_read_req;
    obs_write_req = ddr3_avl_write_req;
    obs_bb        = ddr3_avl_burstbegin;
    obs_addr      = ddr3_avl_addr;
    obs_size      = ddr3_avl_size;
    obs_rd_ack    = rd_ack;
    obs_wr_ack    = wr_ack;
    obs_wdata     = ddr3_avl_wdata;
    obs_busy      = wr_busy;
    chk("read_req",   obs_read_req,  m_kind == 1);
    chk("write_req",  obs_write_req, m_kind == 2);
    chk("burstbegin", obs_bb,        m_first == 1);
    chk("avl_addr",   obs_addr,      (m_kind != 0) ? m_addr : '0);
    chk("avl_size",   obs_size,      (m_kind != 0) ? m_size : 3'd0);
    chk("rd_ack",     obs_rd_ack,    (m_kind == 1) && ddr3_avl_ready);
    chk("wr_ack",     obs_wr_ack,    (m_kind == 2) && ddr3_avl_ready);
    chk("avl_wdata",  obs_wdata,     (m_kind == 2) ? wr_data : '0);
    chk("avl_be",     ddr3_avl_be,   (m_kind == 2) ? wr_be : '0);
    chk("wr_busy",    obs_busy,      m_kind == 2);
    if (ddr3_avl_burstbegin) grant_log.push_back(ddr3_avl_write_req ? 2 : 1);
    rd_acked = rd_ack;
    wr_acked = wr_ack;

    if (!reset_n) begin
      m_kind = 0; m_first = 0; m_starve = 0;
    end else begin
      m_first = 0;
      if (m_kind == 0) begin
`ifdef DDR3_ARB_STARVE_GUARD_EN
        guard = wr_req && (m_starve >= STARVE_LIMIT);
`else
        guard = 0;
`endif
        if (rd_req && !guard) begin
          m_kind = 1; m_first = 1; m_addr = rd_addr; m_size = 3'(nz(rd_size));
          if (wr_req && m_starve < 255) m_starve++;
        end else if (wr_req) begin
          m_kind = 2; m_first = 1; m_addr = wr_addr; m_size = 3'(nz(wr_size));
          m_left = nz(wr_size); m_starve = 0;
        end
      end else if (ddr3_avl_ready) begin
        if (m_kind == 1) m_kind = 0;
        else begin
          m_left--;
          if (m_left == 0) m_kind = 0;
        end
      end
    end

    @(posedge ddr3_clk);
    #1;
    if (!reset_n) begin
      rd_req = 1'b0; wr_req = 1'b0; wr_beat = 0;
    end else begin
      if (rd_acked) rd_req = 1'b0;
      if (wr_acked) begin
        wr_beat++;
        if (wr_beat >= nz(wr_size)) begin
          wr_req = 1'b0; wr_beat = 0;
        end
      end
    end
    if (auto_rd && !rd_req) raise_rd(26'($urandom()), 3'($urandom_range(0, 7)));
    if (auto_wr && !wr_req) raise_wr(26'($urandom()), 3'($urandom_range(0, 7)));
    if (rand_mode) begin
      ddr3_avl_ready = ($urandom_range(0, 3) != 0);
      if (!rd_req && $urandom_range(0, 2) == 0) raise_rd(26'($urandom()), 3'($urandom_range(0, 7)));
      if (!wr_req && $urandom_range(0, 3) == 0) raise_wr(26'($urandom()), 3'($urandom_range(0, 7)));
    end
    update_wdata();
  endtask

  initial begin
`ifdef DDR3_ARB_STARVE_GUARD_EN
    exp_seq = '{1, 1, 1, 2, 1, 1, 1, 2};
`else
    exp_seq = '{1, 1, 1, 1, 1, 1, 1, 1};
`endif
    update_wdata();

    // Reset state.
    repeat (3) tick();
    chk("reset_outputs", {obs_read_req, obs_write_req, obs_bb, obs_addr, obs_size,
                          obs_rd_ack, obs_wr_ack, obs_busy}, '0);
    reset_n = 1'b1;

    // Single read at 0x100, size 4, ready high.
    ddr3_avl_ready = 1'b1;
    raise_rd(26'h100, 3'd4);
    tick();
    chk("t1_arb_cycle_idle", obs_read_req, 1'b0);
    tick();
    chk("t1_read_req", obs_read_req, 1'b1);
    chk("t1_burstbegin", obs_bb, 1'b1);
    chk("t1_rd_ack", obs_rd_ack, 1'b1);
    chk("t1_addr", obs_addr, 26'h100);
    chk("t1_size", obs_size, 3'd4);
    tick();
    chk("t1_outputs_zero", {obs_read_req, obs_write_req, obs_bb, obs_addr, obs_size,
                            obs_rd_ack, obs_wr_ack, obs_busy}, '0);

    // Four-beat write with ready pattern 1,0,1,1,0,1.
    raise_wr(26'h2000, 3'd4);
    tick();
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      ddr3_avl_ready = pat[i][0];
      tick();
      chk("t2_ack_align", obs_wr_ack, pat[i][0]);
      chk("t2_burstbegin", obs_bb, i == 0);
      if (obs_wr_ack) begin
        chk("t2_beat_data", obs_wdata, beat_data(26'h2000, acks));
        acks++;
      end
    end
    chk("t2_ack_count", acks, 4);
    tick();
    chk("t2_busy_fall", obs_busy, 1'b0);

    // Read raised on beat 2 of a write waits for the write and an IDLE cycle.
    ddr3_avl_ready = 1'b1;
    raise_wr(26'h3000, 3'd4);
    tick();
    tick();
    raise_rd(26'h140, 3'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_no_read_mid_write", obs_read_req, 1'b0);
    end
    tick();
    chk("t3_idle_gap", {obs_read_req, obs_write_req}, 2'b00);
    tick();
    chk("t3_read_granted", obs_read_req, 1'b1);
    chk("t3_read_addr", obs_addr, 26'h140);
    tick();

    // Both requesters held continuously: grant order.
    grant_log.delete();
    auto_rd = 1; auto_wr = 1;
    raise_rd(26'h400, 3'd1);
    raise_wr(26'h800, 3'd1);
    for (int i = 0; i < 80 && grant_log.size() < 8; i++) tick();
    chk("t4_grant_count", grant_log.size() >= 8, 1'b1);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t4_grant_%0d", i), (i < grant_log.size()) ? grant_log[i] : 0, exp_seq[i]);
    auto_rd = 0; auto_wr = 0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Zero-size requests become single-beat bursts.
    raise_rd(26'h55, 3'd0);
    tick();
    tick();
    chk("t5_rd_size", obs_size, 3'd1);
    chk("t5_rd_req", obs_read_req, 1'b1);
    tick();
    raise_wr(26'h66, 3'd0);
    tick();
    tick();
    chk("t5_wr_size", obs_size, 3'd1);
    chk("t5_wr_ack", obs_wr_ack, 1'b1);
    tick();
    chk("t5_wr_done", {obs_write_req, obs_busy}, 2'b00);

    // Reset pulse during beat 2 of a four-beat write.
    raise_wr(26'h77, 3'd4);
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    chk("t6_busy_before_reset_edge", obs_busy, 1'b1);
    reset_n = 1'b1;
    tick();
    chk("t6_outputs_zero", {obs_read_req, obs_write_req, obs_bb, obs_addr, obs_size,
                            obs_rd_ack, obs_wr_ack, obs_busy}, '0);
    raise_rd(26'h88, 3'd2);
    tick();
    tick();
    chk("t6_fresh_read", obs_read_req, 1'b1);
    chk("t6_fresh_addr", obs_addr, 26'h88);
    tick();

    // Randomized traffic against the model.
    rand_mode = 1;
    repeat (600) tick();
    rand_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
